// File: rtl/load_unit.sv
// Load stage: issues a word-aligned memory read, then extracts and extends the
// addressed byte/half/word for writeback. Misaligned/illegal loads and timeouts raise fault.
module load_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loadEnabled,
  input  logic [11:0] code,
  input  logic [4:0]  rd,
  input  logic [31:0] dataAlu,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] memAddress,
  output logic        memReadReq,
  output logic        busy,
  output logic [4:0]  rdAddress,
  output logic        writeEnabled_echo,
  output logic [31:0] dataOut,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  funct3_reg;
  logic [4:0]  rd_reg;
  logic [1:0]  offset_reg;
  logic [7:0]  count_reg;
  logic [31:0] mem_address_reg;
  logic [31:0] data_out_reg;
  logic [4:0]  rd_address_reg;
  logic        we_reg;
  logic        fault_reg;

  logic        bad_load;
  logic        accept, reject, complete, timeout;
  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;

  // Only funct3 matters; the remaining opcode bits are intentionally ignored.
  logic unused_code;
  assign unused_code = ^code[11:3];

  always_comb begin
    bad_load = 1'b0;
    case (code[2:0])
      3'b000, 3'b100: bad_load = 1'b0;
      3'b001, 3'b101: bad_load = dataAlu[0];
      3'b010:         bad_load = |dataAlu[1:0];
      default:        bad_load = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    reject     = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (loadEnabled) begin
          if (bad_load) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // A ready on the last permitted cycle still completes normally.
        if (memReady) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (count_reg == LAST_WAIT) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = memData[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[offset_reg];
  assign half_sel = offset_reg[1] ? memData[31:16] : memData[15:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  extracted = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  extracted = {24'd0, byte_sel};
      3'b001:  extracted = {{16{half_sel[15]}}, half_sel};
      3'b101:  extracted = {16'd0, half_sel};
      default: extracted = memData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      funct3_reg      <= 3'd0;
      rd_reg          <= 5'd0;
      offset_reg      <= 2'd0;
      count_reg       <= 8'd0;
      mem_address_reg <= 32'd0;
      data_out_reg    <= 32'd0;
      rd_address_reg  <= 5'd0;
      we_reg          <= 1'b0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      fault_reg <= reject | timeout;
      we_reg    <= complete && (rd_reg != 5'd0);
      if (accept) begin
        funct3_reg      <= code[2:0];
        rd_reg          <= rd;
        offset_reg      <= dataAlu[1:0];
        mem_address_reg <= {dataAlu[31:2], 2'b00};
        count_reg       <= 8'd0;
      end else if (state_reg == REQ && !memReady) begin
        count_reg <= count_reg + 8'd1;
      end
      if (complete) begin
        data_out_reg   <= extracted;
        rd_address_reg <= rd_reg;
      end
    end
  end

  assign memAddress        = mem_address_reg;
  assign memReadReq        = (state_reg == REQ);
  assign busy              = (state_reg != IDLE);
  assign rdAddress         = rd_address_reg;
  assign writeEnabled_echo = we_reg;
  assign dataOut           = data_out_reg;
  assign fault             = fault_reg;

endmodule
